ecc_sed_decoder: RTL and testbench

Single-error-detect (SED) checker that sits directly downstream of the SED encoder and its transport path. It takes the 13-bit even-parity codeword {parity, data[11:0]} with a valid/ready handshake and recomputes parity. It forwards the 12-bit payload through a one-deep registered output stage with an error tag, and keeps a saturating error counter plus a sticky error flag for status software.

---
 rtl/ecc_sed_pkg.sv | 28 ++
 rtl/ecc_sed_decoder_err_counter.sv | 43 ++++
 rtl/ecc_sed_decoder.sv | 80 ++++++++
 tb/tb_ecc_sed_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the single-error-detect (SED) encoder/decoder pair.
// Contents:
//   DATA_W / CW_W / PAR_BIT - payload width, codeword width, parity bit index
//   sed_word_t              - {err, data} as held in the decoder output stage
//   occ_state_t             - output-register occupancy (EMPTY / FULL)
//   sed_parity()            - even-parity bit for a payload; the encoder and
//                             the decoder both call this one definition
package ecc_sed_pkg;

    localparam int DATA_W  = 12;
    localparam int CW_W    = 13;
    localparam int PAR_BIT = 12;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } sed_word_t;

    typedef enum logic {
        OCC_EMPTY = 1'b0,
        OCC_FULL  = 1'b1
    } occ_state_t;

    function automatic logic sed_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ecc_sed_decoder_err_counter.sv
// Saturating parity-error counter plus a sticky error flag.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   clr      - one-cycle clear of counter and flag
//   inc      - an accepted word failed parity this cycle
//   err_flag - sticky error indication
//   err_cnt  - error count, holds at all-ones
// A clear and an increment in the same cycle leave the count at 1: the clear
// is applied first, then the new error is counted.
module ecc_sed_err_counter
    import ecc_sed_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt
);

    logic [CNT_W-1:0] cnt_base;
    logic             flag_base;

    assign cnt_base  = clr ? '0 : err_cnt;
    assign flag_base = clr ? 1'b0 : err_flag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (inc) begin
            err_cnt  <= (&cnt_base) ? cnt_base : cnt_base + 1'b1;
            err_flag <= 1'b1;
        end else begin
            err_cnt  <= cnt_base;
            err_flag <= flag_base;
        end
    end

endmodule

// File: rtl/ecc_sed_decoder.sv
// SED decoder: recomputes even parity over a 13-bit codeword, forwards the
// 12-bit payload through a one-deep registered output stage with an error
// tag, and keeps error statistics for status software.
// Ports:
//   clk, rst                  - clock; synchronous active-low reset
//   enc_valid/enc_ready       - upstream handshake, enc_codeword = {parity, data}
//   dec_valid/dec_ready       - downstream handshake, dec_data + dec_err
//   err_flag, err_cnt, err_clr - sticky flag, saturating count, clear pulse
//
// Output-register occupancy:
//   state     | meaning
//   OCC_EMPTY | no word held, dec_valid=0
//   OCC_FULL  | word held in dec_data/dec_err, dec_valid=1
module ecc_sed_decoder
    import ecc_sed_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DROP_ON_ERR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [CW_W-1:0]   enc_codeword,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_err,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
);

    localparam logic DROP = (DROP_ON_ERR != 0);

    occ_state_t occ;
    sed_word_t  out_q;
    logic       syndrome;
    logic       accept;
    logic       keep_word;

    assign syndrome  = sed_parity(enc_codeword[DATA_W-1:0]) ^ enc_codeword[PAR_BIT];
    // Ready depends only on the registered occupancy and the sink, never on enc_valid.
    assign enc_ready = (occ == OCC_EMPTY) || dec_ready;
    assign accept    = enc_valid && enc_ready;
    assign keep_word = !(DROP && syndrome);

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ   <= OCC_EMPTY;
            out_q <= '0;
        end else if (accept) begin
            // An accept while FULL implies dec_ready, so the held word retires here.
            if (keep_word) begin
                occ   <= OCC_FULL;
                out_q <= '{err: syndrome, data: enc_codeword[DATA_W-1:0]};
            end else begin
                occ <= OCC_EMPTY;
            end
        end else if (occ == OCC_FULL && dec_ready) begin
            occ <= OCC_EMPTY;
        end
    end

    assign dec_valid = (occ == OCC_FULL);
    assign dec_data  = out_q.data;
    assign dec_err   = out_q.err;

    ecc_sed_err_counter #(
        .CNT_W(CNT_W)
    ) u_err_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (err_clr),
        .inc      (accept && syndrome),
        .err_flag (err_flag),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Bench for ecc_sed_decoder. Two instances share one stimulus stream:
//   inst 0: CNT_W=8, DROP_ON_ERR=0 (errors forwarded with dec_err)
//   inst 1: CNT_W=2, DROP_ON_ERR=1 (errors dropped, counter saturates at 3)
module tb_ecc_sed_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enc_valid = 1'b0;
    logic [12:0] enc_codeword = '0;
    logic        dec_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        rdy_a, dv_a, de_a, fl_a;
    logic [11:0] dd_a;
    logic [7:0]  ec_a;
    logic        rdy_b, dv_b, de_b, fl_b;
    logic [11:0] dd_b;
    logic [1:0]  ec_b;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    ecc_sed_decoder #(.CNT_W(8), .DROP_ON_ERR(0)) dut_a (
        .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_ready(rdy_a),
        .enc_codeword(enc_codeword), .dec_valid(dv_a), .dec_ready(dec_ready),
        .dec_data(dd_a), .dec_err(de_a), .err_flag(fl_a), .err_cnt(ec_a),
        .err_clr(err_clr));

    ecc_sed_decoder #(.CNT_W(2), .DROP_ON_ERR(1)) dut_b (
        .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_ready(rdy_b),
        .enc_codeword(enc_codeword), .dec_valid(dv_b), .dec_ready(dec_ready),
        .dec_data(dd_b), .dec_err(de_b), .err_flag(fl_b), .err_cnt(ec_b),
        .err_clr(err_clr));

    // ---------------- behavioural model ----------------
    bit          mv [2] = '{0, 0};
    bit          me [2] = '{0, 0};
    bit          mf [2] = '{0, 0};
    logic [11:0] md [2] = '{12'h0, 12'h0};
    int          mc [2] = '{0, 0};
    int          mmax [2] = '{255, 3};
    bit          mdrop [2] = '{0, 1};

    always @(posedge clk) begin
        int  ones;
        bit  bad;
        bit  take;
        started <= 1'b1;
        ones = $countones(enc_codeword);
        bad  = (ones % 2) != 0;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mv[k] = 0; me[k] = 0; mf[k] = 0; md[k] = '0; mc[k] = 0;
            end else begin
                take = enc_valid && (!mv[k] || dec_ready);
                if (err_clr) begin
                    mc[k] = 0;
                    mf[k] = 0;
                end
                if (take && bad) begin
                    if (mc[k] < mmax[k]) mc[k] = mc[k] + 1;
                    mf[k] = 1;
                end
                if (take) begin
                    if (mdrop[k] && bad) begin
                        mv[k] = 0;
                    end else begin
                        mv[k] = 1;
                        md[k] = enc_codeword[11:0];
                        me[k] = bad;
                    end
                end else if (mv[k] && dec_ready) begin
                    mv[k] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic v, input logic r, input logic [11:0] d,
                       input logic e, input logic f, input logic [31:0] c);
        check($sformatf("m%0d_dec_valid", k), {31'b0, v}, {31'b0, mv[k]});
        check($sformatf("m%0d_enc_ready", k), {31'b0, r}, {31'b0, (!mv[k] || dec_ready)});
        if (mv[k]) begin
            check($sformatf("m%0d_dec_data", k), {20'b0, d}, {20'b0, md[k]});
            check($sformatf("m%0d_dec_err", k), {31'b0, e}, {31'b0, me[k]});
        end
        check($sformatf("m%0d_err_flag", k), {31'b0, f}, {31'b0, mf[k]});
        check($sformatf("m%0d_err_cnt", k), c, mc[k]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp(0, dv_a, rdy_a, dd_a, de_a, fl_a, {24'b0, ec_a});
            cmp(1, dv_b, rdy_b, dd_b, de_b, fl_b, {30'b0, ec_b});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] good_cw(input logic [11:0] d);
        logic p;
        p = ($countones(d) % 2) != 0;
        return {p, d};
    endfunction

    initial begin
        logic [11:0] d;

        cyc(); cyc();
        check("rst_dec_valid", {31'b0, dv_a}, 32'd0);
        check("rst_err_cnt", {24'b0, ec_a}, 32'd0);
        check("rst_enc_ready", {31'b0, rdy_a}, 32'd1);

        rst = 1'b1;
        dec_ready = 1'b1;
        cyc();

        // clean word
        enc_valid = 1'b1; enc_codeword = 13'h0A5C;
        cyc();
        check("clean_valid", {31'b0, dv_a}, 32'd1);
        check("clean_data", {20'b0, dd_a}, 32'hA5C);
        check("clean_err", {31'b0, de_a}, 32'd0);
        check("clean_cnt", {24'b0, ec_a}, 32'd0);

        // parity error
        enc_codeword = 13'h1A5C;
        cyc();
        check("perr_data", {20'b0, dd_a}, 32'hA5C);
        check("perr_err", {31'b0, de_a}, 32'd1);
        check("perr_flag", {31'b0, fl_a}, 32'd1);
        check("perr_cnt", {24'b0, ec_a}, 32'd1);
        check("drop_valid", {31'b0, dv_b}, 32'd0);
        check("drop_cnt", {30'b0, ec_b}, 32'd1);
        enc_valid = 1'b0;
        cyc();

        // backpressure
        dec_ready = 1'b0;
        enc_valid = 1'b1; enc_codeword = 13'h1001;
        cyc();
        check("bp_first_data", {20'b0, dd_a}, 32'h001);
        check("bp_ready_low", {31'b0, rdy_a}, 32'd0);
        enc_codeword = 13'h0003;
        cyc(); cyc();
        check("bp_hold_data", {20'b0, dd_a}, 32'h001);
        check("bp_hold_ready", {31'b0, rdy_a}, 32'd0);
        dec_ready = 1'b1;
        cyc();
        check("bp_second_data", {20'b0, dd_a}, 32'h003);
        check("bp_second_valid", {31'b0, dv_a}, 32'd1);
        enc_valid = 1'b0;
        cyc();
        check("bp_drained", {31'b0, dv_a}, 32'd0);

        // streaming, 16 words back to back
        for (int i = 0; i < 16; i++) begin
            d = 12'(i * 37 + 1);
            enc_valid = 1'b1; enc_codeword = good_cw(d);
            check("stream_ready", {31'b0, rdy_a}, 32'd1);
            cyc();
            check("stream_data", {20'b0, dd_a}, {20'b0, d});
        end
        enc_valid = 1'b0;
        cyc();

        // clear alone, then five errors, then clear+error, then clear alone
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("clr0_cnt_a", {24'b0, ec_a}, 32'd0);
        check("clr0_flag_b", {31'b0, fl_b}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            d = 12'(i * 91 + 3);
            enc_valid = 1'b1; enc_codeword = good_cw(d) ^ 13'h1000;
            cyc();
        end
        check("sat_cnt_b", {30'b0, ec_b}, 32'd3);
        check("sat_cnt_a", {24'b0, ec_a}, 32'd5);
        enc_codeword = 13'h1000 ^ good_cw(12'h7E1);
        err_clr = 1'b1;
        cyc();
        enc_valid = 1'b0;
        err_clr = 1'b0;
        check("clr_err_cnt_b", {30'b0, ec_b}, 32'd1);
        check("clr_err_flag_b", {31'b0, fl_b}, 32'd1);
        check("clr_err_cnt_a", {24'b0, ec_a}, 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("clr_alone_cnt_b", {30'b0, ec_b}, 32'd0);
        check("clr_alone_flag_b", {31'b0, fl_b}, 32'd0);

        // error count to be wiped by reset, plus a held word
        enc_valid = 1'b1; enc_codeword = 13'h1000 ^ good_cw(12'h0F0);
        cyc();
        dec_ready = 1'b0;
        enc_codeword = good_cw(12'h321);
        cyc();
        check("mid_held_valid", {31'b0, dv_a}, 32'd1);
        enc_valid = 1'b0;
        rst = 1'b0;
        cyc();
        check("mid_rst_valid", {31'b0, dv_a}, 32'd0);
        check("mid_rst_cnt", {24'b0, ec_a}, 32'd0);
        check("mid_rst_ready", {31'b0, rdy_a}, 32'd1);
        rst = 1'b1;
        dec_ready = 1'b1;
        cyc(); cyc();
        check("post_rst_valid", {31'b0, dv_a}, 32'd0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
